apb_fifo_slave: RTL and testbench
=================================

# apb_fifo_slave

APB slave that exposes a DEPTH-entry 32-bit data FIFO plus status and control registers. It sits directly downstream of the APB master bridge, next to slave1/slave2, on the shared PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB bus. It returns PRDATA/PREADY/PSLVERR to the bridge's read-data and ready muxes. It adds programmable wait states and error signalling so the bridge's PSLVERR and stretched-access paths get exercised.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- AW, 8: number of PADDR offset bits decoded, PADDR[AW-1:0]. Upper bits are ignored because the bridge performs slave selection.
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESETn  in  1  reset; synchronous, active-low. Same clock and reset scheme as the rest of the APB subsystem.
- PSEL  in  1  slave select from the bridge.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte-lane write strobes.
- PRDATA  out  32  read data; valid only when PREADY=1.
- PREADY  out  1  transfer-complete indicator.
- PSLVERR  out  1  error response; valid only when PREADY=1, otherwise 0.

## Operation
- Register map (offsets on PADDR[AW-1:0]):
  - 0x00 DATA:
    - A write pushes PWDATA and requires PSTRB=4'hF.
    - A read pops the head entry.
  - 0x04 STATUS, read-only:
    - [8:0] count.
    - [16] empty.
    - [17] full.
    - [24] overflow sticky.
    - [25] underflow sticky.
    - Other bits read 0.
  - 0x08 CTRL:
    - [3:0] WAIT, read/write, honours PSTRB[0].
    - [8] FLUSH, write-1 pulse, reads 0, uses PSTRB[1].
    - [16] CLR_STICKY, write-1 pulse, reads 0, uses PSTRB[2].
- All side effects (push, pop, register update, sticky set) commit only on the completion cycle, PSEL & PENABLE & PREADY. A transfer commits exactly once.
- Error cases. Each asserts PSLVERR on the completion cycle and commits no state change except the sticky bit noted:
  - Write to DATA with PSTRB≠4'hF: no push, no sticky.
  - Write to DATA when full: data dropped, overflow sticky set.
  - Read of DATA when empty: PRDATA=0, underflow sticky set.
  - Write to STATUS: ignored.
  - Any unmapped offset: reads return 0.
- FLUSH clears the pointers and count to 0. Sticky bits are kept. FIFO RAM contents are don't-care.
- CLR_STICKY clears both sticky bits. If FLUSH and CLR_STICKY are written together, both take effect.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. full ⇔ count==DEPTH, empty ⇔ count==0.
- Storage uses a register array. Pop data is read combinationally from the head pointer.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, count=0, pointers=0, WAIT=0, sticky bits=0.
- PRESETn low mid-transfer aborts it with no commit. The next cycle presents reset values.
- Setup phase (PSEL=1, PENABLE=0): the wait counter wcnt loads CTRL.WAIT.
- Access phase: PREADY = PSEL & PENABLE & (wcnt==0). While wcnt≠0, wcnt decrements each access cycle.
- An access lasts WAIT+1 cycles. Minimum is 1 cycle, so the transfer is 2 cycles including setup.
- PRDATA and PSLVERR are combinational from registered state and are gated to 0 when PREADY=0.
- A CTRL.WAIT write takes effect from the next transfer's setup phase.
- A pushed word is readable by the immediately following transfer.
- STATUS reflects all commits from earlier transfers.
- If PSEL drops before completion, the transfer is abandoned with no commit, and wcnt reloads at the next setup.
- Back-to-back transfers (setup immediately after a completion) are supported with no idle cycle.

## Configuration
- APB_FIFO_SLV_WAIT_EN defined:
  - CTRL.WAIT and the wait counter are implemented as described above.
- APB_FIFO_SLV_WAIT_EN undefined:
  - No wait counter.
  - PREADY = PSEL & PENABLE.
  - CTRL[3:0] reads 0 and writes to it are ignored without error.
  - All other behaviour is identical.

## Test plan
- Reset, then read STATUS → PRDATA=32'h0001_0000 (empty), PSLVERR=0, PREADY in first access cycle.
- Push 0xA5A5_0001 then 0xA5A5_0002, then read DATA twice → 0xA5A5_0001 then 0xA5A5_0002. Then read STATUS → 0x0001_0000.
- Push DEPTH words 0..15, then a 17th push of 0xDEAD_BEEF → PSLVERR=1 on the 17th, STATUS=0x0102_0010. Drain all 16 → values 0..15 in order; 17th read → PRDATA=0, PSLVERR=1, STATUS bit 25=1.
- Write CTRL=0x0000_0003 with PSTRB=4'h1, then read DATA (non-empty) → PREADY low for 3 access cycles and high on the 4th. With APB_FIFO_SLV_WAIT_EN undefined → PREADY high on the 1st, CTRL reads 0.
- Push with PSTRB=4'h7 → PSLVERR=1, count unchanged. Read at offset 0x0C → PRDATA=0, PSLVERR=1. Write CTRL=0x0001_0100 with PSTRB=4'hF → count=0, sticky bits cleared.
- Assert PRESETn=0 during a wait-stretched push → no push committed, PREADY/PSLVERR/PRDATA=0 next cycle, STATUS=0x0001_0000 after release.

Source files
------------

// File: rtl/apb_fifo_slave.sv
// apb_fifo_slave: APB slave fronting a DEPTH x 32 FIFO with STATUS/CTRL registers; APB_FIFO_SLV_WAIT_EN enables CTRL.WAIT wait states
module apb_fifo_slave #(
    parameter int DEPTH = 16,
    parameter int AW    = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf, unf;
    logic [3:0]    wait_val;
    logic [AW-1:0] off;
    logic          is_data, is_stat, is_ctrl, full, empty, strb_ok, done, err;
    logic          push, pop, ovf_set, unf_set, ctrl_wr, flush, clr;
    logic [8:0]    cnt9;
    logic [31:0]   rdata;
    logic          unused;
    assign unused  = ^PADDR[31:AW];
    assign off     = PADDR[AW-1:0];
    assign is_data = off == AW'(8'h00);
    assign is_stat = off == AW'(8'h04);
    assign is_ctrl = off == AW'(8'h08);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign strb_ok = PSTRB == 4'hF;
    assign cnt9    = 9'(count);
    assign done    = PSEL & PENABLE & PREADY;
    assign push    = done & PWRITE & is_data & strb_ok & !full;
    assign ovf_set = done & PWRITE & is_data & strb_ok & full;
    assign pop     = done & !PWRITE & is_data & !empty;
    assign unf_set = done & !PWRITE & is_data & empty;
    assign ctrl_wr = done & PWRITE & is_ctrl;
    assign flush   = ctrl_wr & PSTRB[1] & PWDATA[8];
    assign clr     = ctrl_wr & PSTRB[2] & PWDATA[16];
    // Every non-CTRL write except a good push, and every read of an empty FIFO or unmapped slot, errors.
    always_comb begin
        err = is_data ? (PWRITE ? (!strb_ok || full) : empty)
            : is_stat ? PWRITE
            : !is_ctrl;
        rdata = is_data ? (empty ? 32'h0 : mem[rd_ptr])
              : is_stat ? {6'b0, unf, ovf, 6'b0, full, empty, 7'b0, cnt9}
              : is_ctrl ? {28'b0, wait_val}
              : 32'h0;
    end
    assign PRDATA  = (PREADY && !PWRITE) ? rdata : 32'h0;
    assign PSLVERR = PREADY & err;
`ifdef APB_FIFO_SLV_WAIT_EN
    logic [3:0] wcnt;
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wcnt     <= '0;
            wait_val <= '0;
        end else begin
            if (PSEL && !PENABLE)
                wcnt <= wait_val;
            else if (PSEL && PENABLE && wcnt != 4'd0)
                wcnt <= wcnt - 4'd1;
            if (ctrl_wr && PSTRB[0])
                wait_val <= PWDATA[3:0];
        end
    end
    // Gated by reset so an access held across reset cannot complete.
    assign PREADY = PRESETn & PSEL & PENABLE & (wcnt == 4'd0);
`else
    assign wait_val = 4'd0;
    assign PREADY   = PRESETn & PSEL & PENABLE;
`endif
    always_ff @(posedge PCLK) begin
        if (push)
            mem[wr_ptr] <= PWDATA;
    end
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (push)
                count <= count + CW'(1);
            else if (pop)
                count <= count - CW'(1);
            ovf <= !clr && (ovf || ovf_set);
            unf <= !clr && (unf || unf_set);
        end
    end
endmodule

// File: tb/tb_apb_fifo_slave.sv
// tb_apb_fifo_slave: randomized self-checking bench for apb_fifo_slave against a queue-based model
module tb_apb_fifo_slave;
`ifdef APB_FIFO_SLV_WAIT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif
    localparam int DEPTH = 16;
    logic        clk = 1'b0;
    logic        PRESETn, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PREADY, PSLVERR;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] q [$];
    bit          m_ovf, m_unf;
    logic [3:0]  m_wait;
    logic [31:0] gr, er;
    logic        ge, ee;
    int          gw, ew;

    apb_fifo_slave #(.DEPTH(DEPTH), .AW(8)) dut (
        .PCLK(clk), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [8:0] c;
        c = 9'(q.size());
        return {6'b0, m_unf, m_ovf, 6'b0, q.size() == DEPTH, q.size() == 0, 7'b0, c};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_wait = 4'd0;
    endtask

    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] erd, output logic eerr);
        logic [7:0] o;
        o = addr[7:0];
        erd = 32'h0;
        eerr = 1'b0;
        if (o == 8'h00) begin
            if (wr) begin
                if (st != 4'hF) eerr = 1'b1;
                else if (q.size() == DEPTH) begin eerr = 1'b1; m_ovf = 1; end
                else q.push_back(wd);
            end else if (q.size() == 0) begin
                eerr = 1'b1;
                m_unf = 1;
            end else erd = q.pop_front();
        end else if (o == 8'h04) begin
            if (wr) eerr = 1'b1;
            else erd = exp_status();
        end else if (o == 8'h08) begin
            if (wr) begin
                if (WEN && st[0]) m_wait = wd[3:0];
                if (st[1] && wd[8]) q.delete();
                if (st[2] && wd[16]) begin m_ovf = 0; m_unf = 0; end
            end else erd = WEN ? {28'b0, m_wait} : 32'h0;
        end else eerr = 1'b1;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err, output int waits);
        @(negedge clk);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = st;
        @(negedge clk);
        PENABLE = 1;
        #1;
        waits = 0;
        while (!PREADY && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!PREADY) waits = -1;
        rd = PRDATA;
        err = PSLVERR;
    endtask

    task automatic idle();
        @(negedge clk);
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic op(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
        ew = WEN ? int'(m_wait) : 0;
        model(wr, addr, wd, st, er, ee);
        xfer(wr, addr, wd, st, gr, ge, gw);
    endtask

    task automatic test_reset();
        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b err=%b rd=%h want 0 0 0", PREADY, PSLVERR, PRDATA);
        end
        PRESETn = 1;
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr !== 32'h0001_0000 || ge !== 1'b0 || gw !== 0) begin
            failures++;
            $display("FAIL reset_status got rd=%h err=%b waits=%0d want 00010000 0 0", gr, ge, gw);
        end
    endtask

    task automatic test_basic();
        op(1, 32'h00, 32'hA5A5_0001, 4'hF);
        op(1, 32'h00, 32'hA5A5_0002, 4'hF);
        checks++;
        if (ge !== 1'b0) begin failures++; $display("FAIL basic_push err=%b want 0", ge); end
        op(0, 32'h00, 0, 0);
        checks++;
        if (gr !== 32'hA5A5_0001 || ge !== 1'b0) begin
            failures++; $display("FAIL basic_pop1 got %h err=%b want a5a50001 0", gr, ge);
        end
        op(0, 32'h00, 0, 0);
        checks++;
        if (gr !== 32'hA5A5_0002 || ge !== 1'b0) begin
            failures++; $display("FAIL basic_pop2 got %h err=%b want a5a50002 0", gr, ge);
        end
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr !== 32'h0001_0000) begin failures++; $display("FAIL basic_status got %h want 00010000", gr); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            op(1, 32'h00, i, 4'hF);
            checks++;
            if (ge !== 1'b0) begin failures++; $display("FAIL fill_%0d err=%b want 0", i, ge); end
        end
        op(1, 32'h00, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (ge !== 1'b1) begin failures++; $display("FAIL overflow_err got %b want 1", ge); end
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr !== 32'h0102_0010) begin failures++; $display("FAIL full_status got %h want 01020010", gr); end
        for (int i = 0; i < DEPTH; i++) begin
            op(0, 32'h00, 0, 0);
            checks++;
            if (gr !== 32'(i) || ge !== 1'b0) begin
                failures++; $display("FAIL drain_%0d got %h err=%b want %h 0", i, gr, ge, 32'(i));
            end
        end
        op(0, 32'h00, 0, 0);
        checks++;
        if (gr !== 32'h0 || ge !== 1'b1) begin
            failures++; $display("FAIL underflow got %h err=%b want 0 1", gr, ge);
        end
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr[25] !== 1'b1 || gr !== er) begin
            failures++; $display("FAIL underflow_status got %h want %h", gr, er);
        end
    endtask

    task automatic test_wait();
        op(1, 32'h08, 32'h0000_0003, 4'h1);
        op(1, 32'h00, 32'h1111_2222, 4'hF);
        op(0, 32'h00, 0, 0);
        checks++;
        if (gw !== (WEN ? 3 : 0) || gr !== 32'h1111_2222 || ge !== 1'b0) begin
            failures++; $display("FAIL wait_read got waits=%0d rd=%h err=%b want %0d 11112222 0", gw, gr, ge, WEN ? 3 : 0);
        end
        op(0, 32'h08, 0, 0);
        checks++;
        if (gr !== (WEN ? 32'h3 : 32'h0) || ge !== 1'b0) begin
            failures++; $display("FAIL ctrl_read got %h err=%b want %h 0", gr, ge, WEN ? 32'h3 : 32'h0);
        end
        op(1, 32'h08, 32'h0, 4'h1);
    endtask

    task automatic test_errors();
        op(1, 32'h00, 32'h7777_7777, 4'hF);
        op(1, 32'h00, 32'h0BAD_0BAD, 4'h7);
        checks++;
        if (ge !== 1'b1) begin failures++; $display("FAIL strb_err got %b want 1", ge); end
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr[8:0] !== 9'd1 || gr !== er) begin failures++; $display("FAIL strb_count got %h want %h", gr, er); end
        op(0, 32'h0C, 0, 0);
        checks++;
        if (gr !== 32'h0 || ge !== 1'b1) begin failures++; $display("FAIL unmapped got %h err=%b want 0 1", gr, ge); end
        op(1, 32'h04, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (ge !== 1'b1) begin failures++; $display("FAIL status_write err=%b want 1", ge); end
        op(1, 32'h08, 32'h0001_0100, 4'hF);
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr !== 32'h0001_0000) begin failures++; $display("FAIL flush_clr got %h want 00010000", gr); end
    endtask

    task automatic test_abandon();
        op(1, 32'h08, 32'h2, 4'h1);
        @(negedge clk);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h0; PWDATA = 32'h5555_AAAA; PSTRB = 4'hF;
        if (WEN) begin
            @(negedge clk);
            PENABLE = 1;
            #1;
            checks++;
            if (PREADY !== 1'b0) begin failures++; $display("FAIL abandon_ready got %b want 0", PREADY); end
        end
        @(negedge clk);
        PSEL = 0; PENABLE = 0;
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr !== er || gw !== ew) begin
            failures++; $display("FAIL abandon_status got %h waits=%0d want %h %0d", gr, gw, er, ew);
        end
        op(1, 32'h00, 32'h0102_0304, 4'hF);
        op(0, 32'h00, 0, 0);
        checks++;
        if (gr !== 32'h0102_0304 || gw !== ew) begin
            failures++; $display("FAIL b2b_pop got %h waits=%0d want 01020304 %0d", gr, gw, ew);
        end
        op(1, 32'h08, 32'h0, 4'h1);
    endtask

    task automatic test_random();
        logic        wr;
        logic [31:0] addr, wd;
        logic [3:0]  st;
        logic [7:0]  o;
        logic [7:0]  odd [4];
        odd = '{8'h0C, 8'h10, 8'h01, 8'hFC};
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            wd = $urandom;
            st = 4'hF;
            wr = 1'b0;
            o = 8'h00;
            case (r)
                0, 1, 2: begin wr = 1; if ($urandom_range(0, 7) == 0) st = 4'($urandom); end
                3, 4, 5: o = 8'h00;
                6: o = 8'h04;
                7: begin
                    wr = 1; o = 8'h08; st = 4'($urandom);
                    wd = {15'b0, $urandom_range(0, 7) == 0, 7'b0, $urandom_range(0, 9) == 0, 4'b0, 4'($urandom_range(0, 3))};
                end
                8: o = 8'h08;
                default: begin
                    wr = 1'($urandom);
                    o = ($urandom_range(0, 3) == 0) ? 8'h04 : odd[$urandom_range(0, 3)];
                    if (o == 8'h04) wr = 1;
                end
            endcase
            addr = ($urandom & 32'hFFFF_FF00) | {24'b0, o};
            op(wr, addr, wd, st);
            checks++;
            if (ge !== ee || gw !== ew || (!wr && gr !== er)) begin
                failures++;
                $display("FAIL rand_%0d wr=%b addr=%h got rd=%h err=%b waits=%0d want rd=%h err=%b waits=%0d",
                         n, wr, addr, gr, ge, gw, er, ee, ew);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        op(1, 32'h08, 32'h3, 4'h1);
        @(negedge clk);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h0; PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF;
        @(negedge clk);
        PENABLE = 1;
        if (WEN) @(negedge clk);
        PRESETn = 0;
        @(negedge clk);
        #1;
        checks++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            failures++; $display("FAIL mid_reset got rdy=%b err=%b rd=%h want 0 0 0", PREADY, PSLVERR, PRDATA);
        end
        PSEL = 0; PENABLE = 0;
        model_reset();
        @(negedge clk);
        PRESETn = 1;
        op(0, 32'h04, 0, 0);
        checks++;
        if (gr !== 32'h0001_0000 || gw !== 0) begin
            failures++; $display("FAIL mid_reset_status got %h waits=%0d want 00010000 0", gr, gw);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wait();
        test_errors();
        test_abandon();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
